lsu_subword: RTL

LSU_SUBWORD -- requirements
Module: lsu_subword

---
 rtl/lsu_pkg.sv | 37 +++
 rtl/lane_merge.sv | 65 ++++++
 rtl/lsu_subword.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_pkg
//  Description : Shared types for the sub-word load/store unit: access-size
//                encoding, controller states and a size-to-bytes helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

   // Access size as presented on req_size
   typedef enum logic [1:0] {
      SZ_WORD   = 2'b00,
      SZ_HALF   = 2'b01,
      SZ_BYTE   = 2'b10,
      SZ_DOUBLE = 2'b11
   } size_e;

   // Controller states
   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RD   = 2'b01,
      ST_WR   = 2'b10,
      ST_RESP = 2'b11
   } state_e;

   // Number of bytes touched by an access of the given size
   function automatic logic [3:0] size_bytes(input size_e sz);
      case (sz)
         SZ_BYTE: size_bytes = 4'd1;
         SZ_HALF: size_bytes = 4'd2;
         SZ_WORD: size_bytes = 4'd4;
         default: size_bytes = 4'd8;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/lane_merge.sv
`default_nettype none
// ============================================================================
//  Module      : lane_merge
//  Description : Combinational byte-lane handling. Extracts and extends the
//                addressed lanes of a memory word for loads, and merges the
//                low bytes of store data into the addressed lanes for stores.
//  Revision    : 1.0 - initial release
// ============================================================================
module lane_merge
   import lsu_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0]              base_word,
   input  logic [DATA_W-1:0]              store_data,
   input  logic [$clog2(DATA_W/8)-1:0]    offset,
   input  logic [1:0]                     size,
   input  logic                           sign_ext,
   output logic [DATA_W-1:0]              merged_word,
   output logic [DATA_W-1:0]              load_data
);
   localparam int OFF_W = $clog2(DATA_W/8);

   logic [OFF_W+2:0]  shamt;
   logic [DATA_W-1:0] shifted;
   logic [DATA_W-1:0] lane_mask;
   logic [DATA_W-1:0] lane_bits;
   logic              lane_msb;

   // Right-justify the addressed lanes and build a mask covering the access width
   always_comb begin
      shamt     = {offset, 3'b000};
      shifted   = base_word >> shamt;
      lane_mask = '0;
      lane_msb  = shifted[DATA_W-1];
      case (size_e'(size))
         SZ_BYTE: begin
            lane_mask[7:0] = '1;
            lane_msb       = shifted[7];
         end
         SZ_HALF: begin
            lane_mask[15:0] = '1;
            lane_msb        = shifted[15];
         end
         SZ_WORD: begin
            lane_mask[31:0] = '1;
            lane_msb        = shifted[31];
         end
         default: begin
            lane_mask = '1;
            lane_msb  = shifted[DATA_W-1];
         end
      endcase
      lane_bits = shifted & lane_mask;
   end

   // Load extension and store merge; a full-width mask passes words through unchanged
   always_comb begin
      load_data   = (sign_ext && lane_msb) ? (lane_bits | ~lane_mask) : lane_bits;
      merged_word = (base_word & ~(lane_mask << shamt))
                  | ((store_data & lane_mask) << shamt);
   end

endmodule
`default_nettype wire

// File: rtl/lsu_subword.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_subword
//  Description : Load/store unit front end translating byte/half/word/double
//                CPU accesses into full-word memory transactions, using a
//                read-modify-write sequence for sub-word stores.
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_subword
   import lsu_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_err,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack
);
   localparam int OFF_W = $clog2(DATA_W/8);
   localparam int BYTES = DATA_W/8;

   state_e            state_q, state_d;
   logic              write_q, write_d;
   size_e             size_q, size_d;
   logic              signed_q, signed_d;
   logic [OFF_W-1:0]  off_q, off_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
   logic              resp_err_q, resp_err_d;

   size_e             req_sz;
   logic [OFF_W-1:0]  req_off;
   logic [3:0]        req_nbytes;
   logic              req_err;
   logic              req_full;
   logic [DATA_W-1:0] merged_word;
   logic [DATA_W-1:0] load_data;

   // Classify the incoming request: misaligned/reserved, and full-width or not
   always_comb begin
      req_sz     = size_e'(req_size);
      req_off    = req_addr[OFF_W-1:0];
      req_nbytes = size_bytes(req_sz);
      req_err    = ((req_sz == SZ_DOUBLE) && (DATA_W == 32))
                || ((4'(req_off) & (req_nbytes - 4'd1)) != 4'd0);
      req_full   = (int'(req_nbytes) == BYTES);
   end

   // Lane extract/merge works on the word returned in the read ack cycle
   lane_merge #(
      .DATA_W (DATA_W)
   ) u_lane_merge (
      .base_word   (mem_rdata),
      .store_data  (wdata_q),
      .offset      (off_q),
      .size        (size_q),
      .sign_ext    (signed_q),
      .merged_word (merged_word),
      .load_data   (load_data)
   );

   // Next-state logic; all captured fields hold unless explicitly updated
   always_comb begin
      state_d      = state_q;
      write_d      = write_q;
      size_d       = size_q;
      signed_d     = signed_q;
      off_d        = off_q;
      wdata_d      = wdata_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      resp_rdata_d = resp_rdata_q;
      resp_err_d   = resp_err_q;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               write_d    = req_write;
               size_d     = req_sz;
               signed_d   = req_signed;
               off_d      = req_off;
               wdata_d    = req_wdata;
               mem_addr_d = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
               if (req_err) begin
                  resp_err_d   = 1'b1;
                  resp_rdata_d = '0;
                  state_d      = ST_RESP;
               end else if (!req_write || !req_full) begin
                  state_d = ST_RD;
               end else begin
                  mem_wdata_d = req_wdata;
                  state_d     = ST_WR;
               end
            end
         end
         ST_RD: begin
            if (mem_ack) begin
               if (!write_q) begin
                  resp_rdata_d = load_data;
                  resp_err_d   = 1'b0;
                  state_d      = ST_RESP;
               end else begin
                  mem_wdata_d = merged_word;
                  state_d     = ST_WR;
               end
            end
         end
         ST_WR: begin
            if (mem_ack) begin
               resp_rdata_d = '0;
               resp_err_d   = 1'b0;
               state_d      = ST_RESP;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         write_q      <= 1'b0;
         size_q       <= SZ_WORD;
         signed_q     <= 1'b0;
         off_q        <= '0;
         wdata_q      <= '0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         resp_rdata_q <= '0;
         resp_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         write_q      <= write_d;
         size_q       <= size_d;
         signed_q     <= signed_d;
         off_q        <= off_d;
         wdata_q      <= wdata_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         resp_rdata_q <= resp_rdata_d;
         resp_err_q   <= resp_err_d;
      end
   end

   // Handshake and strobe outputs decode directly from the registered state
   always_comb begin
      req_ready  = (state_q == ST_IDLE);
      mem_req    = (state_q == ST_RD) || (state_q == ST_WR);
      mem_we     = (state_q == ST_WR);
      resp_valid = (state_q == ST_RESP);
      mem_addr   = mem_addr_q;
      mem_wdata  = mem_wdata_q;
      resp_rdata = resp_rdata_q;
      resp_err   = resp_err_q;
   end

endmodule
`default_nettype wire
